switch_read_ctrl: RTL and testbench

Sequencer for the memory-mapped switch input port (0xFFFFFC70–0xFFFFFC72). It decodes CPU I/O reads aimed at the switch window and stalls the CPU while the user sets the switches. It waits for a debounced press-and-release of a confirm button, then captures the selected switch field and returns it with a one-cycle valid pulse. It sits between the CPU memory/IO stage and the board switches and confirm key.

---
 rtl/io_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 41 ++++
 rtl/switch_read_ctrl.sv | 108 ++++++++++
 tb/tb_switch_read_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped board I/O ports: window base,
// switch field offsets, the switch-read sequencer states and field selection.
package io_pkg;

  localparam logic [31:0] SWITCH_BASE = 32'hFFFFFC70;

  localparam logic [1:0] OFF_LO  = 2'b00;
  localparam logic [1:0] OFF_LO2 = 2'b01;
  localparam logic [1:0] OFF_HI  = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_PRESS = 3'd2,
    WAIT_REL   = 3'd3,
    CAPTURE    = 3'd4,
    DONE       = 3'd5
  } sw_state_t;

  // The high offset returns the top switch byte zero-extended; the two low
  // offsets both return the lower 16 switches.
  function automatic logic [15:0] select_field(input logic [1:0]  off,
                                               input logic [23:0] sw);
    logic [15:0] field;
    case (off)
      OFF_LO, OFF_LO2: field = sw[15:0];
      OFF_HI:          field = {8'h00, sw[23:16]};
      default:         field = sw[15:0];
    endcase
    return field;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for a raw, bouncy board key.
// btn_db only changes after the synchronized level has differed from it for DEBOUNCE_CYCLES edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             db_reg;
  logic [CNT_W-1:0] cnt_reg;

  // The counter restarts whenever the synchronized level returns to the
  // committed level, so any bounce shorter than the window is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b00;
      db_reg   <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
      if (sync_reg[1] == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_reg  <= sync_reg[1];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign btn_db = db_reg;

endmodule

// File: rtl/switch_read_ctrl.sv
// Switch-window read sequencer: stalls a CPU I/O read until the confirm key
// is pressed and released, then returns the selected switch field.
module switch_read_ctrl
  import io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 20,
  parameter logic [31:0] BASE_ADDR       = SWITCH_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioRead,
  input  logic [31:0] addr,
  input  logic        confirm_btn,
  input  logic [23:0] switches,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        waiting
);

  logic        btn_db;
  logic [31:0] addr_off;
  logic        hit;

  sw_state_t   state_reg;
  logic [1:0]  off_reg;
  logic [15:0] rdata_reg;
  logic        valid_reg;
  logic        waiting_reg;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(confirm_btn),
    .btn_db (btn_db)
  );

  // Offset from the window base; only the first three bytes are decoded.
  assign addr_off = addr - BASE_ADDR;
  assign hit      = ioRead && (addr_off < 32'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      off_reg     <= OFF_LO;
      rdata_reg   <= 16'h0000;
      valid_reg   <= 1'b0;
      waiting_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hit) begin
            off_reg     <= addr_off[1:0];
            state_reg   <= ARM;
            waiting_reg <= 1'b1;
          end
        end
        // A key still held from before the request must be released first.
        ARM: begin
          if (!ioRead) begin
            state_reg   <= IDLE;
            waiting_reg <= 1'b0;
          end else if (!btn_db) begin
            state_reg <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!ioRead) begin
            state_reg   <= IDLE;
            waiting_reg <= 1'b0;
          end else if (btn_db) begin
            state_reg   <= WAIT_REL;
            waiting_reg <= 1'b0;
          end
        end
        WAIT_REL: begin
          if (!ioRead) begin
            state_reg <= IDLE;
          end else if (!btn_db) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_reg <= select_field(off_reg, switches);
          valid_reg <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          waiting_reg <= 1'b0;
        end
      endcase
    end
  end

  // The CPU must be held in the very cycle the request is decoded.
  assign stall       = (state_reg == IDLE) ? hit : (state_reg != DONE);
  assign rdata       = rdata_reg;
  assign rdata_valid = valid_reg;
  assign waiting     = waiting_reg;

endmodule

// File: tb/tb_switch_read_ctrl.sv
// Randomized bench for switch_read_ctrl: a rule-level reference model predicts
// every cycle, a scoreboard queue checks each read return.
module tb_switch_read_ctrl;

  localparam int          D    = 4;
  localparam int          NMAX = 4096;
  localparam logic [31:0] BASE = 32'hFFFFFC70;

  logic        clock = 1'b0;
  logic        reset;
  logic        ioRead;
  logic [31:0] addr;
  logic        confirm_btn;
  logic [23:0] switches;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        waiting;

  switch_read_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BASE_ADDR      (BASE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ioRead     (ioRead),
    .addr       (addr),
    .confirm_btn(confirm_btn),
    .switches   (switches),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .waiting    (waiting)
  );

  always #5 clock = ~clock;

  // Stimulus per cycle: values present at the rising edge that ends the cycle.
  bit          s_io   [NMAX];
  logic [31:0] s_addr [NMAX];
  bit          s_btn  [NMAX];
  logic [23:0] s_sw   [NMAX];
  bit          s_rst  [NMAX];
  int          n_cyc = 0;

  // Reference: debounced level and required outputs seen during each cycle.
  bit          m_db    [NMAX+1];
  bit          e_stall [NMAX];
  bit          e_wait  [NMAX];
  bit          e_valid [NMAX];
  logic [15:0] e_rdata [NMAX];

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  int cur      = -1;
  bit finished = 1'b0;
  int errors   = 0;
  int checks   = 0;

  task automatic add(input bit io, input logic [31:0] a, input bit b,
                     input logic [23:0] sw, input bit r);
    if (n_cyc < NMAX) begin
      s_io[n_cyc]   = io;
      s_addr[n_cyc] = a;
      s_btn[n_cyc]  = b;
      s_sw[n_cyc]   = sw;
      s_rst[n_cyc]  = r;
      n_cyc++;
    end
  endtask

  // One CPU read attempt: optional key held beforehand, then io held while the
  // key is released (gap), pressed (press) and released; io stays high for
  // 'tail' cycles after the release. rst_off places a reset inside the read.
  task automatic seg(input logic [31:0] a, input bit held, input int hold,
                     input int gap, input int press, input int tail,
                     input bit rnd_sw, input logic [23:0] sw0, input int rst_off);
    bit          io_on;
    bit          b;
    bit          r;
    logic [23:0] sw;
    int          total;
    io_on = 1'b1;
    total = hold + gap + press + tail;
    if (held)
      for (int i = 0; i < D + 4; i++) add(1'b0, a, 1'b1, rnd_sw ? 24'($urandom) : sw0, 1'b0);
    for (int i = 0; i < total; i++) begin
      if (i < hold)                    b = held;
      else if (i < hold + gap)         b = 1'b0;
      else if (i < hold + gap + press) b = 1'b1;
      else                             b = 1'b0;
      r  = (i == rst_off);
      sw = rnd_sw ? 24'($urandom) : sw0;
      add(io_on && !r, a, b, sw, r);
      if (r) io_on = 1'b0;
    end
    for (int i = 0; i < 8; i++) add(1'b0, a, 1'b0, rnd_sw ? 24'($urandom) : sw0, 1'b0);
  endtask

  function automatic bit eff_btn(input int j, input int last_rst);
    if (j < 0 || j <= last_rst) return 1'b0;
    return s_btn[j];
  endfunction

  // btn_db flips to level s once the synchronized key (two edges late) has
  // shown s, different from btn_db, for D consecutive edges; reset clears all.
  task automatic model_debounce();
    int last_rst;
    bit s;
    bit all_same;
    last_rst = -1000;
    m_db[0]  = 1'b0;
    for (int k = 0; k < n_cyc; k++) begin
      if (s_rst[k]) begin
        m_db[k+1] = 1'b0;
        last_rst  = k;
      end else begin
        s        = eff_btn(k - 2, last_rst);
        all_same = 1'b1;
        for (int j = k - 1 - D; j <= k - 2; j++)
          if (eff_btn(j, last_rst) != s) all_same = 1'b0;
        m_db[k+1] = (all_same && s != m_db[k]) ? s : m_db[k];
      end
    end
  endtask

  function automatic bit is_hit(input int n);
    return s_io[n] && (s_addr[n] >= BASE) && (s_addr[n] <= BASE + 32'd2);
  endfunction

  // Walk the timeline read by read: after a hit, wait for key up, key down,
  // key up again; then one capture cycle and one return cycle.
  task automatic model_reads();
    int          n;
    int          m;
    bit          lost;
    bit          adv;
    bit          target;
    logic [1:0]  off;
    logic [15:0] rd;
    logic [15:0] nd;
    n  = 1;
    rd = 16'h0000;
    while (n < n_cyc) begin
      e_stall[n] = is_hit(n);
      e_wait[n]  = 1'b0;
      e_valid[n] = 1'b0;
      e_rdata[n] = rd;
      if (s_rst[n]) begin
        rd = 16'h0000;
        n++;
      end else if (!is_hit(n)) begin
        n++;
      end else begin
        off  = s_addr[n][1:0];
        m    = n + 1;
        lost = 1'b0;
        for (int p = 0; p < 3; p++) begin
          target = (p == 1);
          adv    = 1'b0;
          while (!lost && !adv) begin
            if (m >= n_cyc) begin
              lost = 1'b1;
            end else begin
              e_stall[m] = 1'b1;
              e_wait[m]  = (p < 2);
              e_valid[m] = 1'b0;
              e_rdata[m] = rd;
              if (s_rst[m]) begin
                rd   = 16'h0000;
                lost = 1'b1;
              end else if (!s_io[m]) begin
                lost = 1'b1;
              end else if (m_db[m] == target) begin
                adv = 1'b1;
              end
              m++;
            end
          end
        end
        if (lost || m + 1 >= n_cyc) begin
          n = m;
        end else begin
          e_stall[m] = 1'b1;
          e_wait[m]  = 1'b0;
          e_valid[m] = 1'b0;
          e_rdata[m] = rd;
          if (s_rst[m]) begin
            rd = 16'h0000;
            n  = m + 1;
          end else begin
            nd = (off == 2'd2) ? {8'h00, s_sw[m][23:16]} : s_sw[m][15:0];
            m++;
            rd         = nd;
            e_stall[m] = 1'b0;
            e_wait[m]  = 1'b0;
            e_valid[m] = 1'b1;
            e_rdata[m] = rd;
            if (s_rst[m]) rd = 16'h0000;
            n = m + 1;
          end
        end
      end
    end
  endtask

  task automatic build_stimulus();
    logic [31:0] a;
    int          sel;
    bit          held;
    int          hold;
    int          gap;
    int          press;
    int          tail;
    int          roff;
    for (int i = 0; i < 3; i++) add(1'b0, 32'h0, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b0, 32'h0, 1'b0, 24'h0, 1'b0);
    // Basic low read and high field read.
    seg(BASE, 1'b0, 0, 3, 10, D + 5, 1'b0, 24'hAB1234, -1);
    seg(BASE + 32'd2, 1'b0, 0, 3, 10, D + 5, 1'b0, 24'hAB1234, -1);
    // Bounce rejection, then abort by dropping ioRead in WAIT_PRESS.
    for (int i = 0; i < 20; i++) add(1'b1, BASE, bit'((i / 2) % 2), 24'h5A5A5A, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b1, BASE, 1'b0, 24'h5A5A5A, 1'b0);
    for (int i = 0; i < 6; i++)  add(1'b0, BASE, 1'b0, 24'h5A5A5A, 1'b0);
    // Key already held when the request arrives.
    seg(BASE + 32'd1, 1'b1, 8, 8, 6, D + 5, 1'b0, 24'h13C0DE, -1);
    // Non-hit addresses.
    for (int i = 0; i < 5; i++) add(1'b1, BASE + 32'd3, 1'b0, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b1, 32'hFFFFFC60, 1'b0, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, BASE, 1'b0, 24'hFFFFFF, 1'b0);
    // Abort in WAIT_PRESS: rdata must keep the last captured value.
    for (int i = 0; i < 6; i++) add(1'b1, BASE, 1'b0, 24'h777777, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, BASE, 1'b0, 24'h777777, 1'b0);
    // Reset while in WAIT_REL, then a clean read.
    seg(BASE, 1'b0, 0, 3, 10, D + 5, 1'b0, 24'h00BEEF, 3 + D + 4);
    seg(BASE, 1'b0, 0, 3, 10, D + 5, 1'b0, 24'h42CAFE, -1);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    a = BASE;
        2:       a = BASE + 32'd1;
        3, 4:    a = BASE + 32'd2;
        5:       a = BASE + 32'd3;
        6:       a = 32'hFFFFFC60;
        default: a = $urandom;
      endcase
      held  = ($urandom_range(0, 3) == 0);
      hold  = held ? $urandom_range(2, 8) : $urandom_range(0, 3);
      gap   = $urandom_range(1, 8);
      press = $urandom_range(1, 12);
      tail  = D + 5;
      if ($urandom_range(0, 3) == 0) tail = $urandom_range(1, D + 9);
      roff = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hold + gap + press) : -1;
      seg(a, held, hold, gap, press, tail, 1'b1, 24'h0, roff);
    end
  endtask

  initial begin
    reset       = 1'b1;
    ioRead      = 1'b0;
    addr        = 32'h0;
    confirm_btn = 1'b0;
    switches    = 24'h0;
    build_stimulus();
    model_debounce();
    model_reads();
    for (int n = 0; n < n_cyc; n++) begin
      if (n > 0) begin
        @(posedge clock);
        #1;
      end
      reset       = s_rst[n];
      ioRead      = s_io[n];
      addr        = s_addr[n];
      confirm_btn = s_btn[n];
      switches    = s_sw[n];
      if (e_valid[n]) sb_q.push_back('{n, e_rdata[n]});
      cur = n;
    end
    @(posedge clock);
    #1;
    finished = 1'b1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!finished && cur >= 1) begin
      checks++;
      if (stall !== e_stall[cur]) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%b required=%b", cur, stall, e_stall[cur]);
      end
      checks++;
      if (waiting !== e_wait[cur]) begin
        errors++;
        $display("FAIL waiting cyc=%0d got=%b required=%b", cur, waiting, e_wait[cur]);
      end
      checks++;
      if (rdata !== e_rdata[cur]) begin
        errors++;
        $display("FAIL rdata_hold cyc=%0d got=%h required=%h", cur, rdata, e_rdata[cur]);
      end
      if (rdata_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d got=1 required=0", cur);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cur || rdata !== e.data) begin
            errors++;
            $display("FAIL read_return cyc=%0d got=%h required=%h at cyc=%0d",
                     cur, rdata, e.data, e.cyc);
          end
        end
      end else if (rdata_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL valid_level cyc=%0d got=%b required=0", cur, rdata_valid);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc < cur) begin
        checks++;
        errors++;
        $display("FAIL missing_valid cyc=%0d got=none required=%h", sb_q[0].cyc, sb_q[0].data);
        void'(sb_q.pop_front());
      end
    end
  end

endmodule
